ball_motion_engine: RTL and testbench

BALL_MOTION_ENGINE -- requirements
Module: ball_motion_engine

---
 rtl/ball_motion_engine.sv | 217 +++++++++++++++++++++
 tb/tb_ball_motion_engine.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_motion_engine.sv
`default_nettype none
// ============================================================================
// Module      : ball_motion_engine
// Description : Single-ball motion engine for a paddle game. A free-running
//               tick divider produces motion steps; an IDLE/SERVE/MOVE/MISS
//               state machine bounces the ball off the side walls and the top,
//               and resolves paddle hits or misses on the paddle row.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        : clock, all state on rising edge
//   rst_n      : asynchronous active-low reset
//   start_i    : serve request (level)
//   swing_i    : player swing, sampled on motion steps
//   clear_i    : synchronous return to IDLE, score zeroed
//   stall_i    : freeze motion while high
//   pat_x_i    : paddle centre x
//   pat_y_i    : paddle row y
//   x_o, y_o   : ball position
//   in_play_o  : high in SERVE and MOVE
//   brk_o      : high in MISS
//   score_o    : saturating hit count
//   level_o    : speed level derived from score
// ============================================================================
module ball_motion_engine #(
    parameter int W        = 11,
    parameter int X_MAX    = 639,
    parameter int TICK_DIV = 250000,
    parameter int PAT_HALF = 32,
    parameter int SW       = 4,
    parameter int LVL_STEP = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          swing_i,
    input  logic          clear_i,
    input  logic          stall_i,
    input  logic [W-1:0]  pat_x_i,
    input  logic [W-1:0]  pat_y_i,
    output logic [W-1:0]  x_o,
    output logic [W-1:0]  y_o,
    output logic          in_play_o,
    output logic          brk_o,
    output logic [SW-1:0] score_o,
    output logic [1:0]    level_o
);

    // One guard bit beyond the sign so y+v near the top of the W range
    // cannot wrap in the signed intermediates.
    localparam int XW = W + 2;
    localparam int CW = $clog2(TICK_DIV);

    localparam logic [CW-1:0]        C_TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [W-1:0]         C_X_MID     = W'(X_MAX / 2);
    localparam logic signed [XW-1:0] C_XMAX_S    = XW'(X_MAX);
    localparam logic signed [XW-1:0] C_HALF_S    = XW'(PAT_HALF);
    localparam logic [SW-1:0]        C_SCORE_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_MOVE  = 2'd2,
        S_MISS  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  x_q, x_d, y_q, y_d;
    logic          dx_left_q, dx_left_d;
    logic          dy_up_q, dy_up_d;
    logic [SW-1:0] score_q, score_d;
    logic          in_play_q, in_play_d;
    logic          brk_q, brk_d;
    logic [CW-1:0] tick_q;
    logic [7:0]    lfsr_q;

    logic                 w_step;
    logic [31:0]          w_lvl_raw;
    logic [1:0]           w_level;
    logic signed [XW-1:0] w_v, w_xs, w_ys, w_pxs, w_pys;
    logic signed [XW-1:0] w_nx, w_ny, w_dxp;
    logic                 w_hit;

    // ------------------------------------------------------------------
    // Tick divider and LFSR run in every state, untouched by clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= '0;
            lfsr_q <= 8'h5A;
        end else begin
            tick_q <= (tick_q == C_TICK_LAST) ? '0 : tick_q + CW'(1);
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign w_step = (tick_q == C_TICK_LAST);

    // Speed level saturates at 3; velocity magnitude is level+1 on both axes.
    assign w_lvl_raw = 32'(score_q) / 32'(LVL_STEP);
    assign w_level   = (w_lvl_raw >= 32'd3) ? 2'd3 : w_lvl_raw[1:0];
    assign w_v       = XW'({1'b0, w_level}) + XW'(1);

    assign w_xs  = $signed({2'b00, x_q});
    assign w_ys  = $signed({2'b00, y_q});
    assign w_pxs = $signed({2'b00, pat_x_i});
    assign w_pys = $signed({2'b00, pat_y_i});

    assign w_nx  = dx_left_q ? (w_xs - w_v) : (w_xs + w_v);
    assign w_ny  = dy_up_q   ? (w_ys - w_v) : (w_ys + w_v);
    // Hit window uses the ball x before this step's horizontal update.
    assign w_dxp = w_xs - w_pxs;
    assign w_hit = swing_i && (w_dxp <= C_HALF_S) && (w_dxp >= -C_HALF_S);

    // ------------------------------------------------------------------
    // Next-state logic: clear > start > stall.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        dx_left_d = dx_left_q;
        dy_up_d   = dy_up_q;
        score_d   = score_q;

        if (clear_i) begin
            state_d = S_IDLE;
            x_d     = C_X_MID;
            y_d     = '0;
            score_d = '0;
        end else begin
            case (state_q)
                S_IDLE, S_MISS: begin
                    if (start_i) state_d = S_SERVE;
                end
                S_SERVE: begin
                    if (!stall_i) begin
                        x_d       = C_X_MID;
                        y_d       = '0;
                        dx_left_d = lfsr_q[0];
                        dy_up_d   = 1'b0;
                        state_d   = S_MOVE;
                    end
                end
                S_MOVE: begin
                    // A step that lands on a stall is dropped, not deferred.
                    if (w_step && !stall_i) begin
                        if (w_nx < 0) begin
                            x_d       = '0;
                            dx_left_d = ~dx_left_q;
                        end else if (w_nx > C_XMAX_S) begin
                            x_d       = W'(X_MAX);
                            dx_left_d = ~dx_left_q;
                        end else begin
                            x_d = w_nx[W-1:0];
                        end

                        if (dy_up_q) begin
                            if (w_ny <= 0) begin
                                y_d     = '0;
                                dy_up_d = 1'b0;
                            end else begin
                                y_d = w_ny[W-1:0];
                            end
                        end else if (w_ny >= w_pys) begin
                            if (w_hit) begin
                                y_d     = pat_y_i - W'(1);
                                dy_up_d = 1'b1;
                                if (score_q != C_SCORE_MAX) score_d = score_q + SW'(1);
                            end else begin
                                y_d     = pat_y_i;
                                state_d = S_MISS;
                            end
                        end else begin
                            y_d = w_ny[W-1:0];
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign in_play_d = (state_d == S_SERVE) || (state_d == S_MOVE);
    assign brk_d     = (state_d == S_MISS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            x_q       <= C_X_MID;
            y_q       <= '0;
            dx_left_q <= 1'b0;
            dy_up_q   <= 1'b0;
            score_q   <= '0;
            in_play_q <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dx_left_q <= dx_left_d;
            dy_up_q   <= dy_up_d;
            score_q   <= score_d;
            in_play_q <= in_play_d;
            brk_q     <= brk_d;
        end
    end

    assign x_o       = x_q;
    assign y_o       = y_q;
    assign in_play_o = in_play_q;
    assign brk_o     = brk_q;
    assign score_o   = score_q;
    assign level_o   = w_level;

endmodule
`default_nettype wire

// File: tb/tb_ball_motion_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_ball_motion_engine
// Description : Self-checking bench for ball_motion_engine with an integer
//               game model, directed scenarios and randomized play.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ball_motion_engine;

    localparam int W        = 11;
    localparam int X_MAX    = 639;
    localparam int TICK_DIV = 4;
    localparam int PAT_HALF = 32;
    localparam int SW       = 4;
    localparam int LVL_STEP = 4;
    localparam int SMAX     = (1 << SW) - 1;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, swing = 1'b0, clear = 1'b0, stall = 1'b0;
    logic [W-1:0]  pat_x = 11'd320, pat_y = 11'd400;
    logic [W-1:0]  x, y;
    logic          in_play, brk;
    logic [SW-1:0] score;
    logic [1:0]    level;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ball_motion_engine #(
        .W(W), .X_MAX(X_MAX), .TICK_DIV(TICK_DIV),
        .PAT_HALF(PAT_HALF), .SW(SW), .LVL_STEP(LVL_STEP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .start_i(start), .swing_i(swing), .clear_i(clear), .stall_i(stall),
        .pat_x_i(pat_x), .pat_y_i(pat_y),
        .x_o(x), .y_o(y), .in_play_o(in_play), .brk_o(brk),
        .score_o(score), .level_o(level)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Game model: plain integers, directions as +1/-1.
    // ------------------------------------------------------------------
    localparam int M_IDLE = 0, M_SERVE = 1, M_MOVE = 2, M_MISS = 3;
    int         m_state = M_IDLE, m_x = X_MAX / 2, m_y = 0, m_dx = 1, m_dy = 1;
    int         m_score = 0, m_tick = 0;
    logic [7:0] m_lfsr  = 8'h5A;
    int         mv, mnx, mny, mox, mdist, mlvl;
    bit         mstep;

    function automatic int lvl_of(input int s);
        int l;
        l = s / LVL_STEP;
        return (l > 3) ? 3 : l;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = M_IDLE; m_x = X_MAX / 2; m_y = 0; m_dx = 1; m_dy = 1;
            m_score = 0; m_tick = 0; m_lfsr = 8'h5A;
        end else begin
            mstep = (m_tick == TICK_DIV - 1);
            mv    = lvl_of(m_score) + 1;
            if (clear) begin
                m_state = M_IDLE; m_x = X_MAX / 2; m_y = 0; m_score = 0;
            end else if (m_state == M_IDLE || m_state == M_MISS) begin
                if (start) m_state = M_SERVE;
            end else if (m_state == M_SERVE) begin
                if (!stall) begin
                    m_x = X_MAX / 2; m_y = 0; m_dy = 1;
                    m_dx = m_lfsr[0] ? -1 : 1;
                    m_state = M_MOVE;
                end
            end else if (mstep && !stall) begin
                mox = m_x;
                mnx = m_x + m_dx * mv;
                if (mnx < 0)          begin m_x = 0;     m_dx = -m_dx; end
                else if (mnx > X_MAX) begin m_x = X_MAX; m_dx = -m_dx; end
                else                  m_x = mnx;
                if (m_dy < 0) begin
                    mny = m_y - mv;
                    if (mny <= 0) begin m_y = 0; m_dy = 1; end
                    else m_y = mny;
                end else begin
                    mny   = m_y + mv;
                    mdist = mox - int'(pat_x);
                    if (mdist < 0) mdist = -mdist;
                    if (mny >= int'(pat_y)) begin
                        if (swing && mdist <= PAT_HALF) begin
                            m_y = int'(pat_y) - 1; m_dy = -1;
                            if (m_score < SMAX) m_score++;
                        end else begin
                            m_y = int'(pat_y); m_state = M_MISS;
                        end
                    end else m_y = mny;
                end
            end
            m_tick = (m_tick + 1) % TICK_DIV;
            m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        end
    end

    // Every cycle: full output vector against the model.
    always @(negedge clk) begin
        logic [29:0] exp_v;
        mlvl  = lvl_of(m_score);
        exp_v = {W'(m_x), W'(m_y),
                 (m_state == M_SERVE || m_state == M_MOVE), (m_state == M_MISS),
                 SW'(m_score), 2'(mlvl)};
        chk("cycle", {x, y, in_play, brk, score, level}, exp_v);
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    bit track_en  = 0;
    int track_off = 0;

    task automatic step_cyc();
        @(negedge clk);
        if (track_en) pat_x = W'(int'(x) + track_off);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step_cyc();
        start = 1'b0;
    endtask

    initial begin
        int n, px, sx, sy, r;

        repeat (3) @(negedge clk);
        chk("reset_x", x, 319);
        chk("reset_y", y, 0);
        chk("reset_in_play", in_play, 0);
        chk("reset_brk", brk, 0);
        chk("reset_score", score, 0);
        chk("reset_level", level, 0);
        rst_n = 1'b1;
        step_cyc();

        // Serve
        pulse_start();
        chk("serve_in_play", in_play, 1);
        n = 0;
        while (y == 0 && n < 16) begin step_cyc(); n++; end
        chk("serve_y", y, 1);
        chk("serve_x", (x == 318 || x == 320), 1);

        // Hits exactly at the window edge until the level changes
        pat_y = 11'd40; swing = 1'b1; track_en = 1; track_off = PAT_HALF;
        n = 0;
        while (score != 4 && n < 4000) begin step_cyc(); n++; end
        chk("hit_score", score, 4);
        chk("hit_y", y, 39);
        chk("hit_level", level, 1);
        n = 0;
        while (y == 39 && n < 12) begin step_cyc(); n++; end
        chk("hit_vel2", y, 37);

        // One pixel outside the window misses
        track_off = PAT_HALF + 1;
        n = 0;
        while (!brk && n < 4000) begin step_cyc(); n++; end
        chk("miss_brk", brk, 1);
        chk("miss_in_play", in_play, 0);
        chk("miss_y", y, 40);
        chk("miss_score", score, 4);
        repeat (3) step_cyc();
        chk("miss_hold_y", y, 40);
        pulse_start();
        chk("reserve_in_play", in_play, 1);
        chk("reserve_brk", brk, 0);
        chk("reserve_score", score, 4);

        // Stall across several steps
        track_off = PAT_HALF;
        repeat (6) step_cyc();
        stall = 1'b1;
        sx = int'(x); sy = int'(y);
        repeat (14) step_cyc();
        chk("stall_x", x, sx);
        chk("stall_y", y, sy);
        chk("stall_in_play", in_play, 1);
        stall = 1'b0;
        repeat (5) step_cyc();

        // Asynchronous reset between edges in MOVE
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_x", x, 319);
        chk("areset_y", y, 0);
        chk("areset_in_play", in_play, 0);
        chk("areset_score", score, 0);
        step_cyc();
        rst_n = 1'b1;
        step_cyc();

        // Earn a point, then clear together with start
        pulse_start();
        n = 0;
        while (score == 0 && n < 2000) begin step_cyc(); n++; end
        chk("pre_clear_score", score, 1);
        clear = 1'b1; start = 1'b1;
        step_cyc();
        clear = 1'b0; start = 1'b0;
        chk("clear_in_play", in_play, 0);
        chk("clear_score", score, 0);
        chk("clear_x", x, 319);
        chk("clear_y", y, 0);
        step_cyc();

        // Left wall bounce with the paddle row out of reach
        track_en = 0; pat_x = 11'd320; pat_y = 11'd2000;
        pulse_start();
        n = 0; px = int'(x);
        while (!(x == 1 && px == 2) && n < 6000) begin px = int'(x); step_cyc(); n++; end
        chk("wall_reach", x, 1);
        n = 0;
        while (x == 1 && n < 10) begin step_cyc(); n++; end
        chk("wall_x0", x, 0);
        n = 0;
        while (x == 0 && n < 10) begin step_cyc(); n++; end
        chk("wall_x1", x, 1);

        // Randomized play
        pat_y = W'($urandom_range(20, 120));
        for (int i = 0; i < 5000; i++) begin
            step_cyc();
            start = ($urandom_range(0, 15) == 0);
            swing = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 9) == 0);
            clear = ($urandom_range(0, 599) == 0);
            r = int'(x) + int'($urandom_range(0, 80)) - 40;
            pat_x = W'((r < 0) ? 0 : r);
            if ($urandom_range(0, 799) == 0) pat_y = W'($urandom_range(20, 120));
        end
        start = 0; swing = 0; stall = 0; clear = 0;
        step_cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
